// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int unsigned DW_DEFAULT = 4;
    localparam int unsigned FIFO_DEPTH = 8;

    // Encodes a one-hot vector of up to 8 requesters into an index.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO write-side bundle; master is the arbiter, slave is the surrounding logic.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = DW_DEFAULT
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    accept;
    logic               fifo_full;
    logic               fifo_wrt_en;
    logic [DW-1:0]      fifo_wrt;
    logic               busy;

    modport master (
        input  req, req_data, fifo_full,
        output gnt, accept, fifo_wrt_en, fifo_wrt, busy
    );

    modport slave (
        output req, req_data, fifo_full,
        input  gnt, accept, fifo_wrt_en, fifo_wrt, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first active request after last_owner, wrapping around.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_owner,
    output logic [NREQ-1:0] pick,
    output logic            any
);
    logic            found;
    logic [IDXW-1:0] idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDXW'((32'(last_owner) + k) % NREQ);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one FIFO among NREQ producers with bounded bursts.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = DW_DEFAULT,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    fifo_wr_arbiter_if.master bus
);
    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned BW   = $clog2(MAX_BURST + 1);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [IDXW-1:0] last_q, last_d;

    logic [IDXW-1:0] owner;
    logic [IDXW-1:0] pick_from;
    logic [NREQ-1:0] pick;
    logic            any_req;
    logic            own_req;
    logic            wen;
    logic            release_c;
    logic [DW-1:0]   owner_data;

    assign owner = IDXW'(onehot_to_idx(8'(gnt_q)));

    // While owning, re-pick relative to the current owner so it becomes lowest priority.
    assign pick_from = (state_q == OWN) ? owner : last_q;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req        (bus.req),
        .last_owner (pick_from),
        .pick       (pick),
        .any        (any_req)
    );

    // Write-port datapath and release decision.
    always_comb begin
        owner_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                owner_data = bus.req_data[i*DW +: DW];
            end
        end
        own_req   = |(gnt_q & bus.req);
        wen       = (state_q == OWN) && own_req && !bus.fifo_full;
        release_c = (state_q == OWN) &&
                    (!own_req || (wen && (burst_q == BW'(MAX_BURST - 1))));

        bus.fifo_wrt_en = wen;
        bus.fifo_wrt    = wen ? owner_data : '0;
        bus.accept      = wen ? gnt_q : '0;
        bus.gnt         = gnt_q;
        bus.busy        = busy_q;
    end

    // Grant FSM next-state.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        burst_d = burst_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = OWN;
                    gnt_d   = pick;
                    busy_d  = 1'b1;
                    burst_d = '0;
                end
            end
            OWN: begin
                if (release_c) begin
                    last_d  = owner;
                    burst_d = '0;
                    if (any_req) begin
                        gnt_d = pick;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else if (wen) begin
                    burst_d = burst_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                burst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            burst_q <= '0;
            last_q  <= IDXW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            burst_q <= burst_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one synchronous FIFO (4-bit data, 8 entries, full/empty flags) among several producers. It owns the FIFO `wrt_en`/`wrt` inputs and observes `full`. Grants are registered, and each requester may hold the port for a bounded burst. The block sits between the producer blocks and the FIFO instance; the read side of the FIFO is not touched.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `DW`, default 4: data width; must match the FIFO data width.
- `MAX_BURST`, default 4: maximum accepted words per grant, ≥1.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NREQ  per-requester write request; level, held while data valid.
- `req_data`  in  NREQ*DW  requester i data in bits `[i*DW +: DW]`.
- `gnt`  out  NREQ  registered one-hot grant; all zero when idle.
- `accept`  out  NREQ  one-hot, combinational; requester's word is written this cycle.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wrt_en`  out  1  FIFO write enable.
- `fifo_wrt`  out  DW  FIFO write data.
- `busy`  out  1  registered; high in OWN state.

## Operation
- **States:**
  - IDLE: no owner.
  - OWN: one requester holds `gnt`.
- **Pick function:** circular priority starting at `last_owner+1` and wrapping. The current owner is therefore lowest priority, and is re-picked only if it is the sole requester.
- **IDLE:** if `|req`, register `gnt` = one-hot(pick), clear `burst_cnt`, go to OWN. Otherwise stay.
- **OWN, owner o:**
  - `fifo_wrt_en = req[o] & ~fifo_full`.
  - `fifo_wrt = req_data[o]`.
  - `accept[o] = fifo_wrt_en`.
  - Each accept increments `burst_cnt`.
- **Release** when either:
  - `req[o]` is low, or
  - an accept occurs with `burst_cnt == MAX_BURST-1`.
- **On release:** `last_owner <= o`. Then re-pick over the current `req` with updated priority:
  - if any request is present, load the new `gnt` directly and stay in OWN with `burst_cnt` cleared (no bubble);
  - otherwise `gnt <= 0` and go to IDLE.
- **Stall:** `fifo_full` high in OWN means no write, no count, and `gnt` is held. A full stall never releases the grant.
- **Width:** `burst_cnt` is `$clog2(MAX_BURST+1)` bits and never exceeds `MAX_BURST-1` at rest.
- **Gating:** `fifo_wrt_en` and `accept` are 0 in IDLE and whenever `gnt` is 0. `fifo_wrt` is 0 when not writing.

## Timing
- **Reset values (async on `rst`):**
  - state IDLE;
  - `gnt = 0`, `busy = 0`, `burst_cnt = 0`;
  - `last_owner = NREQ-1`, so requester 0 wins first;
  - `fifo_wrt_en = 0`, `accept = 0`, `fifo_wrt = 0`.
- **Latency:** `req` rises in IDLE at cycle N, `gnt` is high at N+1, and the first write is at N+1 (if not full).
- **Handover:** release at cycle N; the next owner's `gnt` and first write are at N+1. Zero dead cycles under continuous requests.
- **Requester contract:**
  - keep `req` and data stable until `accept`;
  - on the accept edge, either present the next word or drop `req`;
  - dropping `req` without accept is allowed and releases the grant.
- **Reset mid-burst:** `gnt` and `fifo_wrt_en` drop immediately. No partial state persists. The FIFO is reset on the same `rst`.
- **Simultaneous events:**
  - release and new request from another requester in the same cycle: the new requester is picked at that edge;
  - `fifo_full` and owner dropping `req`: release.
- **`MAX_BURST = 1`:** strict per-word round-robin.

## Structure
- **Shared package `fifo_arb_pkg`:**
  - state enum {IDLE, OWN};
  - `DW_DEFAULT = 4`, `FIFO_DEPTH = 8`;
  - function `onehot_to_idx`.
- **Sub-module `rr_pick`:** combinational, inputs `req[NREQ]` and `last_owner` index, outputs one-hot `pick` and `any`. Used for both the IDLE pick and the release re-pick.
- The FIFO is instantiated alongside this block by the parent, not inside it.

## Test plan
- **Reset:** `rst` pulse, no requests → `gnt = 0`, `fifo_wrt_en = 0`, `busy = 0` during and after reset.
- **Single requester:** `req[2] = 1` with data 0x5,0x6,0x7, then drop → `gnt = 0100` one cycle later, three writes of 5,6,7 on consecutive cycles, release, IDLE, `gnt = 0`.
- **All requesters, `MAX_BURST = 4`:**
  - stimulus: `req = 1111` continuously, each sending its index as data;
  - required FIFO sequence: 0,0,0,0,1,1,1,1 with the FIFO full after 8 writes;
  - drain reads then resume with 2,2,2,2,3,3,3,3;
  - grant order 0→1→2→3→0 with no idle cycles.
- **Full stall:**
  - stimulus: FIFO preloaded to 7 entries, `req[1] = 1`;
  - required: one write, then `fifo_full` = 1;
  - with `gnt` held for 5 cycles, `fifo_wrt_en = 0` and `burst_cnt` frozen;
  - after one read, the write resumes and the burst count continues from 1.
- **Early drop:** owner 3 drops `req` after 2 accepts while `req[0]` is high → `gnt` moves to 0001 on the next edge, and `last_owner = 3`.
- **Async reset mid-burst:** `rst` asserted between edges during owner 1's second write → `gnt` and `fifo_wrt_en` drop before the next edge. After release, `req = 1111` grants requester 0 first.
